// File: rtl/tiny_slot_scheduler.sv
// Time-multiplexes one 8-bit pad slot between NUM_PROJ user designs.
// A switch drains the pads, then holds the new owner in reset before handing it the pads.
module tiny_slot_scheduler #(
   parameter int NUM_PROJ      = 4,
   parameter int GUARD_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 8,
   localparam int IDW = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  sel_req,
   input  logic [IDW-1:0]        sel_id,
   output logic                  sel_ack,
   output logic                  sel_err,
   input  logic [7:0]            pad_in,
   output logic [8*NUM_PROJ-1:0] proj_in,
   input  logic [8*NUM_PROJ-1:0] proj_out,
   output logic [NUM_PROJ-1:0]   proj_rst,
   output logic [7:0]            pad_out,
   output logic [7:0]            pad_oeb,
   output logic [IDW-1:0]        active_id,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   localparam logic [7:0]   GUARD_LD  = 8'(GUARD_CYCLES);
   localparam logic [7:0]   SETTLE_LD = 8'(SETTLE_CYCLES);
   localparam logic [IDW:0] NP        = NUM_PROJ[IDW:0];

   state_t                state_q, state_d;
   logic [IDW-1:0]        active_q, active_d;
   logic [IDW-1:0]        pending_q, pending_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  drive_q, drive_d;
   logic [7:0]            oeb_q, oeb_d;
   logic [NUM_PROJ-1:0]   rst_q, rst_d;
   logic [NUM_PROJ-1:0]   in_en_q, in_en_d;
   logic                  sel_valid;
   logic [7:0]            out_mux;

   assign sel_valid = ({1'b0, sel_id} < NP);

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_ACTIVE: begin
            if (sel_req) begin
               ack_d = 1'b1;
               if (!sel_valid) begin
                  err_d = 1'b1;
               end else if (sel_id != active_q) begin
                  pending_d = sel_id;
                  state_d   = ST_DRAIN;
                  cnt_d     = GUARD_LD;
               end
            end
         end
         ST_DRAIN: begin
            // Ownership moves on the same edge that starts the reset hold.
            if (cnt_q <= 8'd1) begin
               state_d  = ST_SETTLE;
               active_d = pending_q;
               cnt_d    = SETTLE_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q <= 8'd1) begin
               state_d = ST_ACTIVE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
         end
      endcase
   end

   // Output controls are computed from the next state so they are flops, not decodes.
   always_comb begin
      busy_d  = (state_d != ST_ACTIVE);
      drive_d = (state_d == ST_ACTIVE);
      oeb_d   = drive_d ? 8'h00 : 8'hFF;
   end

   generate
      for (genvar gi = 0; gi < NUM_PROJ; gi++) begin : g_proj
         assign rst_d[gi]   = (active_d != IDW'(gi)) || (state_d == ST_SETTLE);
         assign in_en_d[gi] = (active_d == IDW'(gi)) && (state_d != ST_DRAIN);
         assign proj_in[gi*8 +: 8] = in_en_q[gi] ? pad_in : 8'h00;
      end
   endgenerate

   always_comb begin
      out_mux = 8'h00;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (active_q == IDW'(k)) begin
            out_mux = proj_out[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_SETTLE;
         active_q  <= '0;
         pending_q <= '0;
         cnt_q     <= SETTLE_LD;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b1;
         drive_q   <= 1'b0;
         oeb_q     <= 8'hFF;
         rst_q     <= '1;
         in_en_q   <= NUM_PROJ'(1);
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         drive_q   <= drive_d;
         oeb_q     <= oeb_d;
         rst_q     <= rst_d;
         in_en_q   <= in_en_d;
      end
   end

   assign sel_ack   = ack_q;
   assign sel_err   = err_q;
   assign busy      = busy_q;
   assign active_id = active_q;
   assign pad_oeb   = oeb_q;
   assign proj_rst  = rst_q;
   assign pad_out   = drive_q ? out_mux : 8'h00;

endmodule

// File: tb/tb_tiny_slot_scheduler.sv
// Bench for tiny_slot_scheduler: per-cycle pad/reset/input checks plus an ack scoreboard.
module tb_tiny_slot_scheduler;

   localparam int G = 4;
   localparam int S = 8;
   localparam int PH_ACT   = 0;
   localparam int PH_DRAIN = 1;
   localparam int PH_SET   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel_req = 1'b0;
   logic [1:0]  sel_id = 2'd0;
   logic        sel_ack, sel_err, busy;
   logic [7:0]  pad_in = 8'h00;
   logic [31:0] proj_in;
   logic [31:0] proj_out = 32'h0;
   logic [3:0]  proj_rst;
   logic [7:0]  pad_out, pad_oeb;
   logic [1:0]  active_id;

   logic        sel3_req = 1'b0;
   logic [1:0]  sel3_id = 2'd0;
   logic        ack3, err3, busy3;
   logic [23:0] proj_in3;
   logic [23:0] proj_out3 = 24'h332211;
   logic [2:0]  proj_rst3;
   logic [7:0]  pad_out3, pad_oeb3;
   logic [1:0]  active3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acks3 = 0;
   bit hold_req = 1'b0;

   typedef struct {
      int cyc;
      bit err;
   } ack_exp_t;
   ack_exp_t ack_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tiny_slot_scheduler #(.NUM_PROJ(4), .GUARD_CYCLES(G), .SETTLE_CYCLES(S)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .sel_req(sel_req), .sel_id(sel_id),
      .sel_ack(sel_ack), .sel_err(sel_err), .pad_in(pad_in), .proj_in(proj_in),
      .proj_out(proj_out), .proj_rst(proj_rst), .pad_out(pad_out), .pad_oeb(pad_oeb),
      .active_id(active_id), .busy(busy)
   );

   tiny_slot_scheduler #(.NUM_PROJ(3), .GUARD_CYCLES(G), .SETTLE_CYCLES(S)) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst), .sel_req(sel3_req), .sel_id(sel3_id),
      .sel_ack(ack3), .sel_err(err3), .pad_in(pad_in), .proj_in(proj_in3),
      .proj_out(proj_out3), .proj_rst(proj_rst3), .pad_out(pad_out3), .pad_oeb(pad_oeb3),
      .active_id(active3), .busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   always @(negedge clk) begin
      ack_exp_t e;
      if (sel_ack === 1'b1) begin
         if (ack_q.size() == 0) begin
            chk("ack_unexpected", 32'(sel_ack), 32'd0);
         end else begin
            e = ack_q.pop_front();
            chk("ack_cyc", 32'(cyc), 32'(e.cyc));
            chk("ack_err", 32'(sel_err), 32'(e.err));
            $display("ack cyc=%0d err=%0d active=%0d", cyc, sel_err, active_id);
         end
      end
      if (ack3 === 1'b1) acks3++;
   end

   task automatic expect_out(input int ph, input int act);
      logic [7:0]  oeb_e, po_e;
      logic [3:0]  rst_e;
      logic [31:0] pin_e;
      bit          drv;
      drv   = (ph == PH_ACT);
      oeb_e = drv ? 8'h00 : 8'hFF;
      po_e  = drv ? proj_out[act*8 +: 8] : 8'h00;
      rst_e = 4'hF;
      if (ph != PH_SET) rst_e[act] = 1'b0;
      pin_e = 32'h0;
      if (ph != PH_DRAIN) pin_e[act*8 +: 8] = pad_in;
      chk("busy", 32'(busy), 32'(!drv));
      chk("active_id", 32'(active_id), 32'(act));
      chk("pad_oeb", 32'(pad_oeb), 32'(oeb_e));
      chk("pad_out", 32'(pad_out), 32'(po_e));
      chk("proj_rst", 32'(proj_rst), 32'(rst_e));
      chk("proj_in", proj_in, pin_e);
   endtask

   task automatic tick(input int ph, input int act);
      @(posedge clk);
      #1;
      if (!hold_req) sel_req = 1'b0;
      sel3_req = 1'b0;
      pad_in   = 8'($urandom);
      proj_out = $urandom;
      #1;
      expect_out(ph, act);
   endtask

   task automatic run(input int ph, input int act, input int n);
      for (int i = 0; i < n; i++) tick(ph, act);
   endtask

   task automatic req(input int id, input bit exp_err);
      ack_exp_t e;
      sel_req = 1'b1;
      sel_id  = 2'(id);
      e.cyc   = cyc + 1;
      e.err   = exp_err;
      ack_q.push_back(e);
   endtask

   initial begin
      ack_exp_t e;
      int       e0;
      // Reset held for three edges; the cycle after the last one starts the hold count.
      run(PH_SET, 0, 3);
      chk("rst_ack", 32'(sel_ack), 32'd0);
      chk("rst_err", 32'(sel_err), 32'd0);
      rst = 1'b0;
      run(PH_SET, 0, S - 1);
      run(PH_ACT, 0, 3);

      req(0, 1'b0);
      run(PH_ACT, 0, 4);

      req(2, 1'b0);
      run(PH_DRAIN, 0, G);
      run(PH_SET, 2, S);
      run(PH_ACT, 2, 3);
      chk("rst_after_switch", 32'(proj_rst), 32'hB);

      // Invalid id on the three-design instance.
      chk("d3_idle_ack", 32'(ack3), 32'd0);
      sel3_req = 1'b1;
      sel3_id  = 2'd3;
      tick(PH_ACT, 2);
      chk("d3_ack", 32'(ack3), 32'd1);
      chk("d3_err", 32'(err3), 32'd1);
      chk("d3_active", 32'(active3), 32'd0);
      chk("d3_busy", 32'(busy3), 32'd0);
      chk("d3_oeb", 32'(pad_oeb3), 32'h00);
      run(PH_ACT, 2, 1);

      // Request held through the whole switch, then kept while id 1 is active.
      hold_req = 1'b1;
      req(1, 1'b0);
      e0 = cyc + 1;
      run(PH_DRAIN, 2, G);
      run(PH_SET, 1, S);
      run(PH_ACT, 1, 1);
      for (int i = 1; i <= 3; i++) begin
         e.cyc = e0 + G + S + i;
         e.err = 1'b0;
         ack_q.push_back(e);
      end
      run(PH_ACT, 1, 3);
      hold_req = 1'b0;
      sel_req  = 1'b0;
      run(PH_ACT, 1, 2);

      // Reset lands during the third drain cycle toward id 2.
      req(2, 1'b0);
      run(PH_DRAIN, 1, 3);
      rst = 1'b1;
      tick(PH_SET, 0);
      rst = 1'b0;
      for (int i = 0; i < S - 1; i++) begin
         tick(PH_SET, 0);
         chk("id2_no_input", 32'(proj_in[23:16]), 32'h00);
      end
      run(PH_ACT, 0, 3);
      chk("id2_in_reset", 32'(proj_rst[2]), 32'd1);

      run(PH_ACT, 0, 2);
      chk("ack_left", 32'(ack_q.size()), 32'd0);
      chk("d3_ack_count", 32'(acks3), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tiny_slot_scheduler.md
TINY_SLOT_SCHEDULER -- requirements
Module: tiny_slot_scheduler

Interface
REQ-001 SHALL have parameter NUM_PROJ, default 4, number of user designs sharing the 8-bit pad slot (2..8).
REQ-002 SHALL have parameter GUARD_CYCLES, default 4, output-drain cycles before a switch (1..15).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, reset-hold cycles after a switch (1..255).
REQ-004 wb_clk_i  input  1  single clock; all state on rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 sel_req  input  1  request to switch the active design.
REQ-007 sel_id  input  clog2(NUM_PROJ)  requested design index, sampled with sel_req.
REQ-008 sel_ack  output  1  one-cycle pulse: request accepted or rejected.
REQ-009 sel_err  output  1  valid with sel_ack; 1 = rejected.
REQ-010 pad_in  input  8  pad inputs (io_in[19:12]).
REQ-011 proj_in  output  8*NUM_PROJ  per-design inputs; slice k = bits 8k+7:8k.
REQ-012 proj_out  input  8*NUM_PROJ  per-design outputs, same slicing.
REQ-013 proj_rst  output  NUM_PROJ  per-design active-high reset.
REQ-014 pad_out  output  8  to io_out[27:20].
REQ-015 pad_oeb  output  8  to io_oeb[27:20]; 0 = driven.
REQ-016 active_id  output  clog2(NUM_PROJ)  design currently owning the slot.
REQ-017 busy  output  1  high in any state other than ACTIVE.

Function
REQ-018 SHALL implement FSM states ACTIVE, DRAIN, SETTLE.
REQ-019 ACTIVE: pad_out = proj_out slice active_id; pad_oeb = 8'h00; proj_in slice active_id = pad_in.
REQ-020 All non-active proj_in slices SHALL be 8'h00 and their proj_rst bits 1, in every state.
REQ-021 sel_req sampled only in ACTIVE; ignored (no ack) in DRAIN/SETTLE.
REQ-022 In ACTIVE, sel_req with sel_id >= NUM_PROJ: next cycle sel_ack=1, sel_err=1, state unchanged.
REQ-023 In ACTIVE, sel_req with sel_id == active_id: next cycle sel_ack=1, sel_err=0, no switch, no reset pulse.
REQ-024 In ACTIVE, sel_req with valid different sel_id: latch it as pending, next cycle sel_ack=1, sel_err=0, enter DRAIN.
REQ-025 DRAIN: pad_out = 8'h00, pad_oeb = 8'hFF, old design's inputs forced 8'h00; lasts exactly GUARD_CYCLES cycles.
REQ-026 DRAIN exit: active_id <= pending in the same edge that enters SETTLE.
REQ-027 SETTLE: proj_rst[active_id]=1, pad_out=8'h00, pad_oeb=8'hFF, proj_in slice active_id = pad_in; lasts exactly SETTLE_CYCLES cycles.
REQ-028 SETTLE exit: enter ACTIVE, proj_rst[active_id] <= 0; pads driven from the first ACTIVE cycle.
REQ-029 Switch latency: sel_req sampled at edge N -> pads driven by new design from cycle N+1+GUARD_CYCLES+SETTLE_CYCLES.
REQ-030 Phase counter SHALL be 8 bits, reload on each state entry, no wrap past terminal count.
REQ-031 pad_out, pad_oeb, proj_rst, proj_in SHALL be registered (one-cycle delay from proj_out/pad_in acceptable only for pad path if documented; default combinational mux from registered select).
REQ-032 busy SHALL equal (state != ACTIVE), registered.

Reset
REQ-033 wb_rst_i=1 at an edge SHALL force: state=SETTLE, active_id=0, counter=SETTLE_CYCLES, sel_ack=0, sel_err=0, busy=1, pad_oeb=8'hFF, pad_out=8'h00, proj_rst all 1.
REQ-034 Reset SHALL override any in-progress DRAIN/SETTLE and discard the pending id.
REQ-035 After deassertion, design 0 SHALL own the slot after exactly SETTLE_CYCLES cycles.

Verification
REQ-036 Reset 3 cycles, release -> busy=1, pad_oeb=FF for 8 cycles, then active_id=0, pad_oeb=00, pad_out=proj_out[7:0].
REQ-037 In ACTIVE(0), sel_req sel_id=2 one cycle -> ack=1 err=0 next cycle; pad_oeb=FF 4 cycles DRAIN + 8 SETTLE, proj_rst[2]=1 during SETTLE; then pad_out=proj_out[23:16], proj_rst=4'b1011.
REQ-038 sel_req sel_id=0 while active_id=0 -> ack=1 err=0, busy stays 0, no pad_oeb glitch.
REQ-039 NUM_PROJ=3, sel_req sel_id=3 -> ack=1 err=1, active_id unchanged.
REQ-040 sel_req held high during DRAIN/SETTLE with sel_id=1 -> no ack until ACTIVE; then one ack per accepted cycle.
REQ-041 Assert wb_rst_i during 3rd DRAIN cycle toward id 2 -> active_id returns 0, full SETTLE, id 2 never gets inputs.
